// File: rtl/rock_spawner.sv
// rock_spawner: spawn scheduler for the asteroid field.
// Collects spawn tokens from a periodic interval counter and from game
// requests, picks the lowest free rock slot, issues a one-frame start pulse
// with LFSR-derived entry attributes, then waits for the rock to acknowledge.
module rock_spawner #(
    parameter int          NUM_ROCKS      = 8,
    parameter int          SPAWN_INTERVAL = 90,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          ACK_TIMEOUT    = 4
) (
    input  logic                 clk60hz,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 spawn_req,
    input  logic [NUM_ROCKS-1:0] in_use,
    output logic [NUM_ROCKS-1:0] start,
    output logic [9:0]           initialX,
    output logic [9:0]           initialY,
    output logic [2:0]           dirX,
    output logic [2:0]           dirY,
    output logic [4:0]           live_count,
    output logic                 ack_error
);

    typedef enum logic [1:0] {S_IDLE, S_PICK, S_ISSUE, S_WAIT} state_t;

    localparam logic [9:0] IVL_LAST  = 10'(SPAWN_INTERVAL - 1);
    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [9:0]           ivl_q, ivl_d;
    logic [1:0]           tokens_q, tokens_d;
    logic [7:0]           wait_q, wait_d;
    logic [NUM_ROCKS-1:0] slot_q, slot_d;
    logic [NUM_ROCKS-1:0] start_q, start_d;
    logic [9:0]           x_q, x_d, y_q, y_d;
    logic [2:0]           dx_q, dx_d, dy_q, dy_d;
    logic [4:0]           live_q, live_d;
    logic                 ack_err_q, ack_err_d;

    logic [NUM_ROCKS-1:0] free_mask;
    logic                 free_any;
    logic                 wrap;
    logic                 dec;
    logic [9:0]           attr_x, attr_y;
    logic [2:0]           attr_dx, attr_dy;

    // Token count after this frame's increments and issue, floored at 0 and capped at 3.
    function automatic logic [1:0] sat_tokens(input logic [1:0] cur, input logic inc_a,
                                              input logic inc_b, input logic take);
        logic [2:0] sum;
        sum = {1'b0, cur} + {2'b0, inc_a} + {2'b0, inc_b};
        if (take && sum != 3'd0) sum = sum - 3'd1;
        return (sum > 3'd3) ? 2'd3 : sum[1:0];
    endfunction

    // Lowest free slot as a one-hot mask (lowest zero bit of in_use), plus pool popcount.
    always_comb begin
        free_mask = ~in_use & (in_use + NUM_ROCKS'(1));
        free_any  = |free_mask;
        live_d    = '0;
        for (int i = 0; i < NUM_ROCKS; i++) live_d = live_d + 5'(in_use[i]);
    end

    // Entry edge, position and direction decoded from the current LFSR value.
    always_comb begin
        logic [9:0] free_x, free_y;
        logic [1:0] speed;
        logic [2:0] other;
        free_x = {1'b0, lfsr_q[10:2]} + 10'd64;
        free_y = {2'b0, lfsr_q[9:2]} + 10'd112;
        speed  = (lfsr_q[12:11] == 2'd0) ? 2'd1 : lfsr_q[12:11];
        other  = lfsr_q[15:13];
        case (lfsr_q[1:0])
            2'd0:    begin attr_x = free_x;  attr_y = 10'd0;   attr_dx = other;         attr_dy = {1'b0, speed}; end
            2'd1:    begin attr_x = free_x;  attr_y = 10'd479; attr_dx = other;         attr_dy = {1'b1, speed}; end
            2'd2:    begin attr_x = 10'd0;   attr_y = free_y;  attr_dx = {1'b0, speed}; attr_dy = other;         end
            default: begin attr_x = 10'd639; attr_y = free_y;  attr_dx = {1'b1, speed}; attr_dy = other;         end
        endcase
    end

    // Free-running LFSR, interval counter and token bookkeeping.
    always_comb begin
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        wrap     = enable && (ivl_q == IVL_LAST);
        ivl_d    = ivl_q;
        if (enable) ivl_d = wrap ? 10'd0 : ivl_q + 10'd1;
        dec      = (state_q == S_ISSUE);
        tokens_d = sat_tokens(tokens_q, wrap, spawn_req, dec);
    end

    // Spawn FSM: next state, start pulse, attribute latch and acknowledge timeout.
    always_comb begin
        state_d   = state_q;
        start_d   = '0;
        slot_d    = slot_q;
        wait_d    = wait_q;
        ack_err_d = ack_err_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        case (state_q)
            S_IDLE: begin
                if (tokens_q != 2'd0 && free_any) state_d = S_PICK;
            end
            S_PICK: begin
                if (free_any) begin
                    slot_d  = free_mask;
                    start_d = free_mask;
                    x_d     = attr_x;
                    y_d     = attr_y;
                    dx_d    = attr_dx;
                    dy_d    = attr_dy;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                wait_d  = 8'd0;
                state_d = S_WAIT;
            end
            default: begin
                if (|(in_use & slot_q)) begin
                    state_d = S_IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    ack_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
        endcase
    end

    // State and output registers; reset clears the start pulse immediately.
    always_ff @(posedge clk60hz or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lfsr_q    <= LFSR_SEED;
            ivl_q     <= '0;
            tokens_q  <= '0;
            wait_q    <= '0;
            slot_q    <= '0;
            start_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            live_q    <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            ivl_q     <= ivl_d;
            tokens_q  <= tokens_d;
            wait_q    <= wait_d;
            slot_q    <= slot_d;
            start_q   <= start_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            live_q    <= live_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign start      = start_q;
    assign initialX   = x_q;
    assign initialY   = y_q;
    assign dirX       = dx_q;
    assign dirY       = dy_q;
    assign live_count = live_q;
    assign ack_error  = ack_err_q;

endmodule

// File: tb/tb_rock_spawner.sv
// Testbench for rock_spawner: directed scenarios plus a randomized spawn sweep
// checked against a frame-level reference model of the spawn rules.
module tb_rock_spawner;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk60hz = 1'b0;
    logic       reset;
    logic       enable;
    logic       spawn_req;
    logic [7:0] in_use;
    logic [7:0] start;
    logic [9:0] initialX, initialY;
    logic [2:0] dirX, dirY;
    logic [4:0] live_count;
    logic       ack_error;

    rock_spawner #(
        .NUM_ROCKS(8), .SPAWN_INTERVAL(4), .LFSR_SEED(SEED), .ACK_TIMEOUT(4)
    ) dut (
        .clk60hz(clk60hz), .reset(reset), .enable(enable), .spawn_req(spawn_req),
        .in_use(in_use), .start(start), .initialX(initialX), .initialY(initialY),
        .dirX(dirX), .dirY(dirY), .live_count(live_count), .ack_error(ack_error)
    );

    always #5 clk60hz = ~clk60hz;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_start = -100;
    int          spawns = 0;
    bit          auto_ack;
    bit          rst_at_edge;
    logic [15:0] lfsr_m, lfsr_prev;
    logic [7:0]  in_at_edge;
    logic [7:0]  starts_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    function automatic logic [7:0] lowest_free(input logic [7:0] u);
        for (int i = 0; i < 8; i++) if (!u[i]) return 8'(1 << i);
        return 8'h00;
    endfunction

    function automatic void ref_spawn(input logic [15:0] v, output logic [9:0] x, output logic [9:0] y,
                                      output logic [2:0] dx, output logic [2:0] dy);
        int side, fx, fy, spd, oth;
        side = int'(v) % 4;
        fx   = (int'(v) / 4) % 512 + 64;
        fy   = (int'(v) / 4) % 256 + 112;
        spd  = (int'(v) / 2048) % 4;
        if (spd == 0) spd = 1;
        oth  = int'(v) / 8192;
        case (side)
            0:       begin x = 10'(fx); y = 10'd0;   dx = 3'(oth);     dy = 3'(spd);     end
            1:       begin x = 10'(fx); y = 10'd479; dx = 3'(oth);     dy = 3'(4 + spd); end
            2:       begin x = 10'd0;   y = 10'(fy); dx = 3'(spd);     dy = 3'(oth);     end
            default: begin x = 10'd639; y = 10'(fy); dx = 3'(4 + spd); dy = 3'(oth);     end
        endcase
    endfunction

    // Advance one frame: update the model at the edge, check outputs at the falling edge.
    task automatic frame();
        logic [9:0] ex, ey;
        logic [2:0] edx, edy;
        logic [1:0] side;
        @(posedge clk60hz);
        in_at_edge  = in_use;
        rst_at_edge = reset;
        lfsr_prev   = lfsr_m;
        lfsr_m      = reset ? SEED : lfsr_step(lfsr_m);
        cyc++;
        @(negedge clk60hz);
        check("lfsr", dut.lfsr_q, lfsr_m);
        check("live_count", live_count, rst_at_edge ? 0 : $countones(in_at_edge));
        if (start != 8'h00) begin
            ref_spawn(lfsr_prev, ex, ey, edx, edy);
            side = lfsr_prev[1:0];
            check("start_onehot", $onehot(start), 1);
            check("start_slot", start, lowest_free(in_at_edge));
            check("start_spacing", (cyc - last_start) >= 4, 1);
            check("spawn_x", initialX, ex);
            check("spawn_y", initialY, ey);
            check("spawn_dx", dirX, edx);
            check("spawn_dy", dirY, edy);
            check("x_range", initialX <= 10'd639, 1);
            check("y_range", initialY <= 10'd479, 1);
            case (side)
                2'd0:    check("inward_top",    {dirY[2], dirY[1:0] != 2'd0, initialY}, {1'b0, 1'b1, 10'd0});
                2'd1:    check("inward_bottom", {dirY[2], dirY[1:0] != 2'd0, initialY}, {1'b1, 1'b1, 10'd479});
                2'd2:    check("inward_left",   {dirX[2], dirX[1:0] != 2'd0, initialX}, {1'b0, 1'b1, 10'd0});
                default: check("inward_right",  {dirX[2], dirX[1:0] != 2'd0, initialX}, {1'b1, 1'b1, 10'd639});
            endcase
            last_start = cyc;
            starts_q.push_back(start);
            spawns++;
            if (auto_ack) in_use = in_use | start;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int found;
        int base;
        int idx;
        reset = 1'b1; enable = 1'b0; spawn_req = 1'b0; in_use = 8'h00;
        auto_ack = 1'b1; lfsr_m = SEED;
        frame(); frame();
        check("rst_start", start, 0);
        check("rst_x", initialX, 0);
        check("rst_y", initialY, 0);
        check("rst_dx", dirX, 0);
        check("rst_dy", dirY, 0);
        check("rst_live", live_count, 0);
        check("rst_ackerr", ack_error, 0);
        reset = 1'b0;
        frame();

        // Single request into an empty pool.
        starts_q.delete();
        spawn_req = 1'b1; frame(); spawn_req = 1'b0;
        check("t1_n0", start, 8'h00);
        frame(); check("t1_n1", start, 8'h00);
        frame(); check("t1_n2", start, 8'h01);
        frame(); check("t1_n3", start, 8'h00);
        repeat (8) frame();
        check("t1_count", starts_q.size(), 1);
        check("t1_tokens", dut.tokens_q, 0);

        // Three back-to-back requests with slots 0..2 busy.
        in_use = 8'h07; starts_q.delete();
        spawn_req = 1'b1; frame(); frame(); frame(); spawn_req = 1'b0;
        check("t2_tokens_sat", dut.tokens_q, 3);
        repeat (20) frame();
        check("t2_count", starts_q.size(), 3);
        check("t2_s0", starts_q[0], 8'h08);
        check("t2_s1", starts_q[1], 8'h10);
        check("t2_s2", starts_q[2], 8'h20);
        check("t2_live", live_count, 6);

        // Full pool with periodic tokens, then free slot 6 and later slots 0 and 1.
        in_use = 8'hFF; enable = 1'b1; starts_q.delete();
        repeat (20) frame();
        check("t3_nostart", starts_q.size(), 0);
        check("t3_tokens", dut.tokens_q, 3);
        enable = 1'b0; in_use[6] = 1'b0;
        frame(); check("t3_f1", start, 8'h00);
        frame(); check("t3_f2", start, 8'h40);
        in_use = in_use & 8'hFC;
        repeat (20) frame();
        check("t3_count", starts_q.size(), 3);
        check("t3_s1", starts_q[1], 8'h01);
        check("t3_s2", starts_q[2], 8'h02);
        check("t3_tokens_end", dut.tokens_q, 0);

        // No acknowledge: timeout sets the sticky error, retry goes to the same slot.
        auto_ack = 1'b0; in_use = 8'hF0; starts_q.delete();
        spawn_req = 1'b1; frame(); spawn_req = 1'b0;
        frame(); frame();
        check("t4_start", start, 8'h01);
        repeat (4) frame();
        check("t4_err_early", ack_error, 0);
        frame();
        check("t4_err_set", ack_error, 1);
        spawn_req = 1'b1; frame(); spawn_req = 1'b0;
        frame(); frame();
        check("t4_retry", start, 8'h01);
        check("t4_err_sticky", ack_error, 1);
        repeat (6) frame();

        // Randomized sweep of spawns against the reference model.
        auto_ack = 1'b1; in_use = 8'(($urandom));
        base = spawns;
        for (int k = 0; k < 30000 && (spawns - base) < 1000; k++) begin
            spawn_req = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 3) == 0);
            frame();
            if (start == 8'h00 && $urandom_range(0, 1) == 1) begin
                idx = int'($urandom_range(0, 7));
                in_use[idx] = 1'b0;
            end
        end
        check("t5_spawns", (spawns - base) >= 1000, 1);

        // Reset landing in the ISSUE frame.
        enable = 1'b0; spawn_req = 1'b0; in_use = 8'h00;
        repeat (12) frame();
        spawn_req = 1'b1; frame(); spawn_req = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            frame();
            if (start != 8'h00) found = 1;
        end
        check("t6_reached_issue", found, 1);
        reset = 1'b1;
        #1;
        check("t6_start", start, 0);
        check("t6_x", initialX, 0);
        check("t6_y", initialY, 0);
        check("t6_dx", dirX, 0);
        check("t6_dy", dirY, 0);
        check("t6_live", live_count, 0);
        check("t6_ackerr", ack_error, 0);
        check("t6_lfsr", dut.lfsr_q, SEED);
        frame();
        reset = 1'b0; in_use = 8'h00; starts_q.delete();
        repeat (8) frame();
        check("t6_no_leftover", starts_q.size(), 0);
        spawn_req = 1'b1; frame(); spawn_req = 1'b0;
        frame(); frame();
        check("t6_after_reset", start, 8'h01);
        repeat (4) frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
